// File: rtl/skullfet_test_pkg.sv
// Shared types and constants for the SKULLFET inverter self-test sequencer.
package skullfet_test_pkg;

  // Sequencer states. IDLE waits for start, APPLY/SETTLE/CHECK walk one
  // vector, DONE emits the completion pulse.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int LFSR_W = 8;

  // Feedback taps for x^8+x^6+x^5+x^4+1 in the shift-left form used here:
  // bits 7, 5, 4 and 3 of the current value XOR into the new bit 0.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  // Value loaded on reset and in place of an all-zero seed, which would
  // otherwise lock the register at zero.
  localparam logic [LFSR_W-1:0] LFSR_RESEED = 8'h01;

  // One Fibonacci step: shift left, feedback parity into the LSB.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/skullfet_lfsr8.sv
// 8-bit Fibonacci LFSR producing the pseudo-random stimulus sequence.
// load takes priority over enable; a zero seed is replaced by the reseed value.
module skullfet_lfsr8
  import skullfet_test_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              enable,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  // Register update: reset, seed load, or one step per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_RESEED;
    end else if (load) begin
      state <= (seed == '0) ? LFSR_RESEED : seed;
    end else if (enable) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/skullfet_test_sequencer.sv
// Self-test controller for the SKULLFET inverter cells.
//
// Each vector: APPLY drives l[NUM_CH-1:0] onto the inverter inputs, SETTLE
// waits SETTLE_CYCLES cycles while the cells and the 2-flop synchronizer
// catch up, CHECK compares the synchronized outputs against ~drive_o and
// accumulates results. A run is N such vectors followed by a one-cycle DONE.
//
// Control handshake: start is a level sampled only in IDLE; abort is a level
// sampled only in APPLY/SETTLE/CHECK. Neither is acknowledged; busy marks the
// window in which abort is honoured, done pulses once on normal completion.
module skullfet_test_sequencer
  import skullfet_test_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  n_vectors,
  input  logic [7:0]        seed,
  input  logic [NUM_CH-1:0] sense_i,
  output logic [NUM_CH-1:0] drive_o,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  vec_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [NUM_CH-1:0] fail_mask,
  output logic [CNT_W-1:0]  first_fail_idx
);

  // Settle counter holds SETTLE_CYCLES-1 down to 0 (SETTLE_CYCLES >= 2).
  localparam int SET_W = $clog2(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  state_t              state;
  state_t              state_n;

  logic [SET_W-1:0]    settle_cnt;
  logic [CNT_W-1:0]    n_lat;
  logic [NUM_CH-1:0]   sync_1;
  logic [NUM_CH-1:0]   sync_2;
  logic [LFSR_W-1:0]   lfsr_q;
  logic                unused_lfsr;

  // Per-cycle strobes decoded by the FSM and consumed by the datapath.
  logic                run_start;
  logic                apply_en;
  logic                settle_dec;
  logic                check_en;
  logic                finish_en;
  logic                abort_en;

  logic [NUM_CH-1:0]   mismatch;
  logic [CNT_W-1:0]    vec_next;

  // A channel fails when its synchronized output is not the inverse of what
  // was driven.
  assign mismatch = sync_2 ^ ~drive_o;
  assign vec_next = vec_count + CNT_W'(1);

  // Upper LFSR bits only feed the sequence, not the stimulus.
  assign unused_lfsr = ^lfsr_q;

  // Busy spans the vector loop; done is the DONE state itself.
  assign busy = (state == APPLY) || (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);

  skullfet_lfsr8 u_lfsr (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .load   (run_start),
    .enable (check_en),
    .seed   (seed),
    .state  (lfsr_q)
  );

  // Two-flop synchronizer on the asynchronous inverter outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= sense_i;
      sync_2 <= sync_1;
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and strobe decode. Abort wins over any work in the loop
  // states, so a CHECK that coincides with abort leaves results untouched.
  always_comb begin
    state_n    = state;
    run_start  = 1'b0;
    apply_en   = 1'b0;
    settle_dec = 1'b0;
    check_en   = 1'b0;
    finish_en  = 1'b0;
    abort_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          run_start = 1'b1;
          state_n   = (n_vectors == '0) ? DONE : APPLY;
        end
      end
      APPLY: begin
        if (abort) begin
          abort_en = 1'b1;
          state_n  = IDLE;
        end else begin
          apply_en = 1'b1;
          state_n  = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          abort_en = 1'b1;
          state_n  = IDLE;
        end else if (settle_cnt == '0) begin
          state_n = CHECK;
        end else begin
          settle_dec = 1'b1;
        end
      end
      CHECK: begin
        if (abort) begin
          abort_en = 1'b1;
          state_n  = IDLE;
        end else begin
          check_en = 1'b1;
          state_n  = (vec_next == n_lat) ? DONE : APPLY;
        end
      end
      DONE: begin
        finish_en = 1'b1;
        state_n   = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Stimulus drive and settle timer.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      drive_o    <= '0;
      settle_cnt <= '0;
    end else begin
      if (apply_en) begin
        drive_o    <= lfsr_q[NUM_CH-1:0];
        settle_cnt <= SETTLE_LOAD;
      end else if (settle_dec) begin
        settle_cnt <= settle_cnt - SET_W'(1);
      end
      if (finish_en || abort_en) begin
        drive_o <= '0;
      end
    end
  end

  // Run bookkeeping: cleared at start, updated once per CHECK, held
  // otherwise until the next start. The first failure of a run is the one
  // seen while err_count is still zero.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      n_lat          <= '0;
      vec_count      <= '0;
      err_count      <= '0;
      fail_mask      <= '0;
      first_fail_idx <= '1;
      aborted        <= 1'b0;
    end else begin
      if (run_start) begin
        n_lat          <= n_vectors;
        vec_count      <= '0;
        err_count      <= '0;
        fail_mask      <= '0;
        first_fail_idx <= '1;
        aborted        <= 1'b0;
      end
      if (check_en) begin
        fail_mask <= fail_mask | mismatch;
        vec_count <= vec_next;
        if (mismatch != '0) begin
          if (err_count != '1) begin
            err_count <= err_count + CNT_W'(1);
          end
          if (err_count == '0) begin
            first_fail_idx <= vec_count;
          end
        end
      end
      if (abort_en) begin
        aborted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_skullfet_test_sequencer.sv
// Bench for skullfet_test_sequencer: three instances (default, longer settle,
// 4-bit counters) each with a behavioural inverter-cell model on sense_i.
module tb_skullfet_test_sequencer;

  localparam int NCH     = 2;
  localparam int S_M     = 4;
  localparam int M_IDEAL = 0;
  localparam int M_STUCK = 1;
  localparam int M_INV   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // ---------------- main instance (S=4, CNT_W=16) ----------------
  logic             start_m = 1'b0;
  logic             abort_m = 1'b0;
  logic [15:0]      nvec_m  = '0;
  logic [7:0]       seed_m  = '0;
  logic [NCH-1:0]   sense_m;
  logic [NCH-1:0]   drive_m;
  logic             busy_m, done_m, aborted_m;
  logic [15:0]      vec_m, err_m, first_m;
  logic [NCH-1:0]   mask_m;

  skullfet_test_sequencer #(.NUM_CH(NCH), .SETTLE_CYCLES(S_M), .CNT_W(16)) u_main (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_m), .abort(abort_m),
    .n_vectors(nvec_m), .seed(seed_m), .sense_i(sense_m), .drive_o(drive_m),
    .busy(busy_m), .done(done_m), .aborted(aborted_m), .vec_count(vec_m),
    .err_count(err_m), .fail_mask(mask_m), .first_fail_idx(first_m));

  // Cell model: registered inverter with dly_m cycles of delay, optionally
  // one channel stuck, or wrong polarity (sense follows drive).
  logic [NCH-1:0] pipe_m [4];
  int   dly_m     = 1;
  int   mode_m    = M_IDEAL;
  int   stuck_ch  = 1;
  logic stuck_val = 1'b0;

  always @(posedge clk) begin
    pipe_m[0] <= ~drive_m;
    for (int i = 1; i < 4; i++) pipe_m[i] <= pipe_m[i-1];
  end

  always_comb begin
    sense_m = pipe_m[dly_m-1];
    if (mode_m == M_STUCK) sense_m[stuck_ch] = stuck_val;
    else if (mode_m == M_INV) sense_m = ~pipe_m[dly_m-1];
  end

  // ---------------- instance B (S=5), 3-cycle cell delay ----------------
  logic             start_b = 1'b0;
  logic [15:0]      nvec_b  = '0;
  logic [7:0]       seed_b  = '0;
  logic [NCH-1:0]   sense_b, drive_b, mask_b;
  logic             busy_b, done_b, aborted_b;
  logic [15:0]      vec_b, err_b, first_b;
  logic [NCH-1:0]   pipe_b [3];

  skullfet_test_sequencer #(.NUM_CH(NCH), .SETTLE_CYCLES(5), .CNT_W(16)) u_s5 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_b), .abort(1'b0),
    .n_vectors(nvec_b), .seed(seed_b), .sense_i(sense_b), .drive_o(drive_b),
    .busy(busy_b), .done(done_b), .aborted(aborted_b), .vec_count(vec_b),
    .err_count(err_b), .fail_mask(mask_b), .first_fail_idx(first_b));

  always @(posedge clk) begin
    pipe_b[0] <= ~drive_b;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign sense_b = pipe_b[2];

  // ---------------- instance C (CNT_W=4), always-mismatch cell ----------------
  logic             start_c = 1'b0;
  logic [3:0]       nvec_c  = '0;
  logic [7:0]       seed_c  = '0;
  logic [NCH-1:0]   sense_c, drive_c, mask_c;
  logic             busy_c, done_c, aborted_c;
  logic [3:0]       vec_c, err_c, first_c;

  skullfet_test_sequencer #(.NUM_CH(NCH), .SETTLE_CYCLES(S_M), .CNT_W(4)) u_c4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_c), .abort(1'b0),
    .n_vectors(nvec_c), .seed(seed_c), .sense_i(sense_c), .drive_o(drive_c),
    .busy(busy_c), .done(done_c), .aborted(aborted_c), .vec_count(vec_c),
    .err_count(err_c), .fail_mask(mask_c), .first_fail_idx(first_c));

  always @(posedge clk) sense_c <= drive_c;

  // ---------------- reference model ----------------
  // Walks the stimulus sequence from the LFSR rule and decides each vector's
  // mismatch from the cell behaviour: an in-tolerance cell matches, a cell too
  // slow for the settle window still shows the previous vector's answer.
  task automatic model_run(input logic [7:0] sd, input int n, input int mode,
                           input bit lag, input int sch, input logic sval,
                           input int cnt_w, output int e_vec, output int e_err,
                           output logic [NCH-1:0] e_mask, output int e_first);
    logic [7:0]     l;
    logic [NCH-1:0] cur, prev, mm;
    int             maxv;
    maxv    = (1 << cnt_w) - 1;
    l       = (sd == 8'h00) ? 8'h01 : sd;
    prev    = '0;
    e_err   = 0;
    e_mask  = '0;
    e_first = maxv;
    for (int j = 0; j < n; j++) begin
      cur = l[NCH-1:0];
      mm  = '0;
      if (mode == M_IDEAL) mm = lag ? (cur ^ prev) : '0;
      else if (mode == M_STUCK) mm[sch] = (cur[sch] == sval);
      else mm = '1;
      if (mm != '0) begin
        if (e_err == 0) e_first = j;
        if (e_err < maxv) e_err = e_err + 1;
      end
      e_mask = e_mask | mm;
      prev   = cur;
      l      = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    e_vec = n % (maxv + 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Start pulse; returns in the cycle after the start edge.
  task automatic kick_main(input logic [7:0] sd, input logic [15:0] n);
    seed_m = sd; nvec_m = n; start_m = 1'b1;
    step(1);
    start_m = 1'b0;
  endtask

  // Cycles from the first post-start cycle until done is seen (bounded).
  task automatic wait_done_main(output int cyc);
    cyc = 0;
    while (done_m !== 1'b1 && cyc < 3000) begin step(1); cyc++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (drive_m !== 2'b00) begin errors++; $display("FAIL reset_drive: got %0h want 0", drive_m); end
    checks++; if ({busy_m, done_m, aborted_m} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy_m, done_m, aborted_m}); end
    checks++; if (vec_m !== 16'h0 || err_m !== 16'h0) begin errors++; $display("FAIL reset_counts: got vec=%0h err=%0h want 0/0", vec_m, err_m); end
    checks++; if (mask_m !== 2'b00 || first_m !== 16'hFFFF) begin errors++; $display("FAIL reset_mask_first: got %0h/%0h want 0/ffff", mask_m, first_m); end
    rst = 1'b0;
    step(2);
    checks++; if (busy_m !== 1'b0 || done_m !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b done=%b want 0/0", busy_m, done_m); end
  endtask

  task automatic test_ideal();
    int cyc;
    mode_m = M_IDEAL; dly_m = 1;
    kick_main(8'h01, 16'd4);
    checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL ideal_busy: got %b want 1", busy_m); end
    wait_done_main(cyc);
    checks++; if (cyc != 24) begin errors++; $display("FAIL ideal_done_time: got %0d want 24", cyc); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL ideal_busy_in_done: got %b want 0", busy_m); end
    step(1);
    checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL ideal_done_pulse: got %b want 0", done_m); end
    checks++; if (vec_m !== 16'd4 || err_m !== 16'd0) begin errors++; $display("FAIL ideal_counts: got vec=%0d err=%0d want 4/0", vec_m, err_m); end
    checks++; if (mask_m !== 2'b00 || first_m !== 16'hFFFF) begin errors++; $display("FAIL ideal_mask_first: got %0h/%0h want 0/ffff", mask_m, first_m); end
    checks++; if (drive_m !== 2'b00) begin errors++; $display("FAIL ideal_drive_idle: got %0h want 0", drive_m); end
  endtask

  task automatic test_stuck();
    int cyc;
    mode_m = M_STUCK; dly_m = 1; stuck_ch = 1; stuck_val = 1'b0;
    kick_main(8'h01, 16'd4);
    checks++; if (drive_m !== 2'b00) begin errors++; $display("FAIL stuck_drive_in_apply: got %0h want 0", drive_m); end
    step(1);
    checks++; if (drive_m !== 2'b01) begin errors++; $display("FAIL stuck_first_drive: got %0h want 1", drive_m); end
    step(6);
    checks++; if (drive_m !== 2'b10) begin errors++; $display("FAIL stuck_second_drive: got %0h want 2", drive_m); end
    wait_done_main(cyc);
    step(1);
    checks++; if (err_m !== 16'd3 || vec_m !== 16'd4) begin errors++; $display("FAIL stuck_counts: got err=%0d vec=%0d want 3/4", err_m, vec_m); end
    checks++; if (mask_m !== 2'b10 || first_m !== 16'd0) begin errors++; $display("FAIL stuck_mask_first: got %0h/%0h want 2/0", mask_m, first_m); end
  endtask

  // 3-cycle cell: too slow for S=4 (sees previous vector), fine for S=5.
  task automatic test_delay();
    int cyc;
    mode_m = M_IDEAL; dly_m = 3;
    kick_main(8'h01, 16'd4);
    wait_done_main(cyc);
    step(1);
    checks++; if (err_m !== 16'd3 || mask_m !== 2'b11 || first_m !== 16'd0) begin errors++; $display("FAIL delay_s4: got err=%0d mask=%0h first=%0h want 3/3/0", err_m, mask_m, first_m); end
    seed_b = 8'h01; nvec_b = 16'd4; start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    cyc = 0;
    while (done_b !== 1'b1 && cyc < 3000) begin step(1); cyc++; end
    checks++; if (cyc != 28) begin errors++; $display("FAIL delay_s5_time: got %0d want 28", cyc); end
    step(1);
    checks++; if (err_b !== 16'd0 || mask_b !== 2'b00 || vec_b !== 16'd4 || first_b !== 16'hFFFF) begin errors++; $display("FAIL delay_s5: got err=%0d mask=%0h vec=%0d first=%0h want 0/0/4/ffff", err_b, mask_b, vec_b, first_b); end
    dly_m = 1;
  endtask

  task automatic test_abort_settle();
    mode_m = M_STUCK; dly_m = 1; stuck_ch = 1; stuck_val = 1'b0;
    kick_main(8'h01, 16'd10);
    step(13);
    abort_m = 1'b1;
    step(1);
    abort_m = 1'b0;
    checks++; if (busy_m !== 1'b0 || drive_m !== 2'b00 || aborted_m !== 1'b1) begin errors++; $display("FAIL abort_settle_state: busy=%b drive=%0h aborted=%b want 0/0/1", busy_m, drive_m, aborted_m); end
    checks++; if (vec_m !== 16'd2 || err_m !== 16'd1 || mask_m !== 2'b10 || first_m !== 16'd0) begin errors++; $display("FAIL abort_settle_partial: vec=%0d err=%0d mask=%0h first=%0h want 2/1/2/0", vec_m, err_m, mask_m, first_m); end
    for (int i = 0; i < 40; i++) begin
      checks++; if (done_m !== 1'b0 || busy_m !== 1'b0) begin errors++; $display("FAIL abort_no_done: cycle %0d done=%b busy=%b want 0/0", i, done_m, busy_m); end
      step(1);
    end
  endtask

  // Abort coinciding with the first CHECK: that vector is not recorded.
  task automatic test_abort_check();
    mode_m = M_INV; dly_m = 1;
    kick_main(8'h5C, 16'd3);
    checks++; if (aborted_m !== 1'b0) begin errors++; $display("FAIL start_clears_aborted: got %b want 0", aborted_m); end
    step(5);
    abort_m = 1'b1;
    step(1);
    abort_m = 1'b0;
    checks++; if (aborted_m !== 1'b1 || vec_m !== 16'd0 || err_m !== 16'd0) begin errors++; $display("FAIL abort_check: aborted=%b vec=%0d err=%0d want 1/0/0", aborted_m, vec_m, err_m); end
    checks++; if (mask_m !== 2'b00 || first_m !== 16'hFFFF) begin errors++; $display("FAIL abort_check_mask: got %0h/%0h want 0/ffff", mask_m, first_m); end
  endtask

  task automatic test_zero_vectors();
    kick_main(8'h33, 16'd0);
    checks++; if (done_m !== 1'b1 || busy_m !== 1'b0 || aborted_m !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b busy=%b aborted=%b want 1/0/0", done_m, busy_m, aborted_m); end
    abort_m = 1'b1;
    step(1);
    checks++; if (done_m !== 1'b0 || aborted_m !== 1'b0 || vec_m !== 16'd0) begin errors++; $display("FAIL zero_after: done=%b aborted=%b vec=%0d want 0/0/0", done_m, aborted_m, vec_m); end
    step(2);
    abort_m = 1'b0;
    checks++; if (aborted_m !== 1'b0 || busy_m !== 1'b0) begin errors++; $display("FAIL idle_abort_ignored: aborted=%b busy=%b want 0/0", aborted_m, busy_m); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    mode_m = M_IDEAL; dly_m = 1;
    kick_main(8'h01, 16'd4);
    step(8);
    start_m = 1'b1; nvec_m = 16'd2; seed_m = 8'h5A;
    step(3);
    start_m = 1'b0;
    wait_done_main(cyc);
    checks++; if (cyc + 11 != 24) begin errors++; $display("FAIL start_ignored_time: got %0d want 24", cyc + 11); end
    step(1);
    checks++; if (vec_m !== 16'd4 || err_m !== 16'd0) begin errors++; $display("FAIL start_ignored_counts: vec=%0d err=%0d want 4/0", vec_m, err_m); end
  endtask

  task automatic test_saturate();
    int cyc;
    seed_c = 8'($urandom_range(0, 255)); nvec_c = 4'd15; start_c = 1'b1;
    step(1);
    start_c = 1'b0;
    cyc = 0;
    while (done_c !== 1'b1 && cyc < 3000) begin step(1); cyc++; end
    checks++; if (cyc != 90) begin errors++; $display("FAIL sat_time: got %0d want 90", cyc); end
    step(1);
    checks++; if (err_c !== 4'hF || vec_c !== 4'hF || first_c !== 4'h0 || mask_c !== 2'b11) begin errors++; $display("FAIL sat_counts: err=%0h vec=%0h first=%0h mask=%0h want f/f/0/3", err_c, vec_c, first_c, mask_c); end
  endtask

  task automatic test_reset_mid_run();
    mode_m = M_INV; dly_m = 1;
    kick_main(8'h01, 16'd10);
    step(14);
    checks++; if (vec_m !== 16'd2 || err_m !== 16'd2 || busy_m !== 1'b1) begin errors++; $display("FAIL midrun_progress: vec=%0d err=%0d busy=%b want 2/2/1", vec_m, err_m, busy_m); end
    rst = 1'b1;
    step(1);
    checks++; if (busy_m !== 1'b0 || drive_m !== 2'b00 || vec_m !== 16'd0 || err_m !== 16'd0 || mask_m !== 2'b00 || first_m !== 16'hFFFF) begin errors++; $display("FAIL midrun_reset: busy=%b drive=%0h vec=%0d err=%0d mask=%0h first=%0h", busy_m, drive_m, vec_m, err_m, mask_m, first_m); end
    rst = 1'b0;
    step(40);
    checks++; if (busy_m !== 1'b0 || done_m !== 1'b0) begin errors++; $display("FAIL midrun_stays_idle: busy=%b done=%b want 0/0", busy_m, done_m); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [7:0]     sd;
      logic [NCH-1:0] em;
      int             n, cyc, ev, ee, ef;
      bit             lag;
      sd        = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      n         = $urandom_range(1, 12);
      mode_m    = $urandom_range(0, 2);
      dly_m     = (mode_m == M_IDEAL && $urandom_range(0, 1) == 1) ? 3 : 1;
      stuck_ch  = $urandom_range(0, NCH - 1);
      stuck_val = 1'($urandom_range(0, 1));
      lag       = (dly_m > S_M - 2);
      model_run(sd, n, mode_m, lag, stuck_ch, stuck_val, 16, ev, ee, em, ef);
      kick_main(sd, 16'(n));
      wait_done_main(cyc);
      checks++; if (cyc != n * (S_M + 2)) begin errors++; $display("FAIL rand_time[%0d]: got %0d want %0d", it, cyc, n * (S_M + 2)); end
      step(1);
      checks++; if (vec_m !== 16'(ev) || err_m !== 16'(ee)) begin errors++; $display("FAIL rand_counts[%0d]: vec=%0d err=%0d want %0d/%0d", it, vec_m, err_m, ev, ee); end
      checks++; if (mask_m !== em || first_m !== 16'(ef)) begin errors++; $display("FAIL rand_mask_first[%0d]: mask=%0h first=%0h want %0h/%0h", it, mask_m, first_m, em, ef); end
    end
    dly_m = 1;
  endtask

  // Second start asserted during DONE: ignored there, taken in IDLE.
  task automatic test_back_to_back();
    int             cyc, ev, ee, ef;
    logic [NCH-1:0] em;
    mode_m = M_STUCK; dly_m = 1; stuck_ch = 0; stuck_val = 1'b1;
    kick_main(8'hA7, 16'd5);
    wait_done_main(cyc);
    seed_m = 8'h3C; nvec_m = 16'd6; start_m = 1'b1;
    step(1);
    model_run(8'hA7, 5, M_STUCK, 1'b0, 0, 1'b1, 16, ev, ee, em, ef);
    checks++; if (vec_m !== 16'(ev) || err_m !== 16'(ee) || mask_m !== em || first_m !== 16'(ef)) begin errors++; $display("FAIL b2b_first: vec=%0d err=%0d mask=%0h first=%0h want %0d/%0d/%0h/%0h", vec_m, err_m, mask_m, first_m, ev, ee, em, ef); end
    step(1);
    start_m = 1'b0;
    checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL b2b_restart: busy=%b want 1", busy_m); end
    wait_done_main(cyc);
    checks++; if (cyc != 36) begin errors++; $display("FAIL b2b_time: got %0d want 36", cyc); end
    step(1);
    model_run(8'h3C, 6, M_STUCK, 1'b0, 0, 1'b1, 16, ev, ee, em, ef);
    checks++; if (vec_m !== 16'(ev) || err_m !== 16'(ee) || mask_m !== em || first_m !== 16'(ef)) begin errors++; $display("FAIL b2b_second: vec=%0d err=%0d mask=%0h first=%0h want %0d/%0d/%0h/%0h", vec_m, err_m, mask_m, first_m, ev, ee, em, ef); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    step(3);
    test_reset();
    test_ideal();
    test_stuck();
    test_delay();
    test_abort_settle();
    test_abort_check();
    test_zero_vectors();
    test_start_ignored();
    test_saturate();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
